alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Operation sequencer that sits in front of the 8-bit combinational ALU and drives its `a`/`b`/`s` inputs. It accepts operation requests over a valid/ready handshake and runs the request through the ALU: single-cycle for native ALU opcodes, or as an 8-iteration shift-add unsigned multiply that uses the ALU's ADD. It returns the registered result and a `{Z,N,C,V}` flag nibble over a second valid/ready handshake.

## Interface
- `MUL_OP`, default `4'b1111`: request opcode that selects multiply. All other opcodes pass straight to the ALU.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request. High only in IDLE.
- `req_op`  in  4  ALU select code, or `MUL_OP`.
- `req_a`, `req_b`  in  8  operands. For MUL, `req_a` is the multiplicand and `req_b` is the multiplier.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_lo`  out  8  result (low byte of the product for MUL).
- `rsp_hi`  out  8  high byte of the product for MUL. 0 for all other ops.
- `rsp_flags`  out  4  `{Z,N,C,V}`.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_s`  out  4  ALU select.
- `alu_out`  in  8  ALU result.
- `alu_z`, `alu_n`, `alu_c`, `alu_v`  in  1  ALU flags.

## Operation
- **States:** IDLE, EXEC, MUL, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `op`, `A`, `B`.
  - If `op`==`MUL_OP`: clear `P_hi`, set `Q`=`B`, `M`=`A`, count=0, go to MUL.
  - Otherwise go to EXEC.
- **EXEC**
  - Drive `alu_s`=`op`, `alu_a`=`A`, `alu_b`=`B`.
  - At the edge, capture `rsp_lo`=`alu_out`, `rsp_hi`=0, `rsp_flags`={`alu_z`,`alu_n`,`alu_c`,`alu_v`}, then go to RESP.
  - Undefined ALU codes pass through unchanged (the ALU yields 0, flags 4'b1000).
- **MUL** (one iteration per cycle, 8 iterations)
  - Drive `alu_s`=4'b0000 (ADD), `alu_a`=`P_hi`, `alu_b`=`Q[0]` ? `M` : 8'h00.
  - At the edge: {`P_hi`,`Q`} <= {`alu_c`, `alu_out`, `Q`} >> 1 (17-bit right shift; the ALU carry enters bit 15). Count increments.
  - After the 8th iteration (count 7→8), capture `rsp_lo`=`Q`, `rsp_hi`=`P_hi` as shifted, then go to RESP.
  - Product is the unsigned 16-bit value {`P_hi`,`Q`}.
  - MUL flags:
    - Z = (product==0), all 16 bits.
    - N = product[15].
    - C = (`rsp_hi`!=0), meaning the product does not fit in 8 bits.
    - V = 0.
- **RESP**
  - `rsp_valid`=1. `rsp_*` held constant until `rsp_valid`&&`rsp_ready`, then go to IDLE.
  - `req_valid` is ignored outside IDLE.
- **ALU drive in IDLE and RESP:** `alu_a`=`alu_b`=0, `alu_s`=4'b0000.
- **Reset:** asynchronous clear of all state. Effects take hold immediately, with no clock edge needed.
  - State goes to IDLE, so `req_ready`=1.
  - `rsp_valid`=0; `rsp_lo`, `rsp_hi`, `rsp_flags`=0; `alu_*` outputs=0.
  - Any in-flight operation is discarded with no response.

## Timing
- Request acceptance at edge E0.
- **Native op:** EXEC during cycle E0–E1. `rsp_valid` rises after E1, giving a latency of 1 cycle.
- **MUL:** iterations at E1..E8. `rsp_valid` rises after E8, giving a latency of 8 cycles.
- Response handshake at edge Er.
  - `req_ready` rises after Er.
  - The earliest next acceptance is Er+1.
  - No back-to-back overlap: at most one operation in flight.
- `rsp_ready` may be high before `rsp_valid`. The handshake then completes at the first edge with `rsp_valid`=1.
- The ALU is combinational. The `alu_out`→register path must close within one cycle.

## Test plan
All scenarios instantiate the real ALU on the `alu_*` ports.
- ADD `req_op`=0000, `a`=0x7F, `b`=0x01 -> `rsp_lo`=0x80, `rsp_hi`=0, `rsp_flags`=0101. `rsp_valid` one cycle after accept.
- SUB `req_op`=0001, `a`=0x05, `b`=0x05 -> `rsp_lo`=0x00, `rsp_flags`=1010 (Z, no-borrow C).
- MUL `a`=0xFF, `b`=0xFF -> `rsp_hi`=0xFE, `rsp_lo`=0x01, `rsp_flags`=0110. `rsp_valid` exactly 8 cycles after accept.
- MUL `a`=0x10, `b`=0x10 -> `rsp_hi`=0x01, `rsp_lo`=0x00, flags 0010. Then MUL `a`=0x00, `b`=0x37 -> 0x0000, flags 1000.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` while pulsing `req_valid` -> `rsp_*` stable, `req_ready`=0, extra request not accepted. Then `rsp_ready`=1 -> IDLE next cycle.
- Assert `rst_n`=0 mid-MUL (after iteration 4) -> `rsp_valid`=0 and `req_ready`=1 immediately. After release, ADD 0x01+0x02 returns 0x03, flags 0000.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequencer in front of the 8-bit ALU: single-cycle native ops
// and an 8-step shift-add unsigned multiply that reuses ALU ADD.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_op/req_a/req_b  : opcode (MUL_OP selects multiply), operands
//   rsp_valid/rsp_ready : response handshake
//   rsp_lo/rsp_hi       : result / product bytes (hi=0 for native ops)
//   rsp_flags           : {Z,N,C,V}
//   alu_a/alu_b/alu_s   : drive to the combinational ALU
//   alu_out, alu_z/n/c/v: ALU result and flags
module alu_mul_seq #(
  parameter logic [3:0] MUL_OP = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_lo,
  output logic [7:0] rsp_hi,
  output logic [3:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  // b_q doubles as the multiplier shift register Q during MUL
  logic [7:0] b_q, b_d;
  logic [7:0] phi_q, phi_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic [3:0] flg_q, flg_d;

  // {carry, sum, Q} shifted right by one
  logic [7:0] mul_hi;
  logic [7:0] mul_lo;
  assign mul_hi = {alu_c, alu_out[7:1]};
  assign mul_lo = {alu_out[0], b_q[7:1]};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    phi_d   = phi_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_s   = 4'b0000;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          phi_d = 8'h00;
          cnt_d = 3'd0;
          if (req_op == MUL_OP) state_d = S_MUL;
          else                  state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_s   = op_q;
        alu_a   = a_q;
        alu_b   = b_q;
        lo_d    = alu_out;
        hi_d    = 8'h00;
        flg_d   = {alu_z, alu_n, alu_c, alu_v};
        state_d = S_RESP;
      end
      S_MUL: begin
        alu_s = 4'b0000;
        alu_a = phi_q;
        alu_b = b_q[0] ? a_q : 8'h00;
        phi_d = mul_hi;
        b_d   = mul_lo;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          lo_d    = mul_lo;
          hi_d    = mul_hi;
          flg_d   = {~|{mul_hi, mul_lo}, mul_hi[7],
                     |mul_hi, 1'b0};
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      phi_q   <= 8'h00;
      cnt_q   <= 3'd0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      flg_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      phi_q   <= phi_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flg_q   <= flg_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_flags = flg_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a behavioural 8-bit ALU on alu_*.
// Directed steps; expected responses go through a queue.
module tb_alu_mul_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_lo;
  logic [7:0] rsp_hi;
  logic [3:0] rsp_flags;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_out;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;

  always #5 clk = ~clk;

  alu_mul_seq #(.MUL_OP(4'b1111)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_flags (rsp_flags),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_c     (alu_c),
    .alu_v     (alu_v)
  );

  // Behavioural ALU: ADD, SUB (C = no borrow), AND, OR, XOR;
  // undefined codes give 0 with flags 1000.
  logic [8:0] alu_w;
  always_comb begin
    alu_w = 9'h000;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_s)
      4'h0: begin
        alu_w = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = alu_w[8];
        alu_v = (alu_a[7] == alu_b[7]) &&
                (alu_w[7] != alu_a[7]);
      end
      4'h1: begin
        alu_w = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c = (alu_a >= alu_b);
        alu_v = (alu_a[7] != alu_b[7]) &&
                (alu_w[7] != alu_a[7]);
      end
      4'h2: alu_w = {1'b0, alu_a & alu_b};
      4'h3: alu_w = {1'b0, alu_a | alu_b};
      4'h4: alu_w = {1'b0, alu_a ^ alu_b};
      default: alu_w = 9'h000;
    endcase
    alu_out = alu_w[7:0];
    alu_z   = (alu_w[7:0] == 8'h00);
    alu_n   = alu_w[7];
  end

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] fl;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cmp_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lo"}, rsp_lo, e.lo);
      chk({tag, "_hi"}, rsp_hi, e.hi);
      chk({tag, "_fl"}, rsp_flags, e.fl);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Accept at E0; returns with rsp_valid seen (or timeout).
  task automatic issue(input string tag,
                       input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input int lat);
    int n;
    logic [3:0] es;
    logic [7:0] ea;
    logic [7:0] eb;
    wait_ready(tag);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (op == 4'hF) begin
      es = 4'h0; ea = 8'h00; eb = b[0] ? a : 8'h00;
    end else begin
      es = op; ea = a; eb = b;
    end
    chk({tag, "_alu_s"}, alu_s, es);
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, eb);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_idle_valid"}, rsp_valid, 0);
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input exp_t e);
    sb.push_back(e);
    issue(tag, op, a, b, (op == 4'hF) ? 8 : 1);
    cmp_rsp(tag);
    chk({tag, "_alu_idle"}, {alu_s, alu_a, alu_b}, 0);
    finish_rsp(tag);
  endtask

  function automatic exp_t mul_model(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [15:0] p;
    exp_t e;
    p    = a * b;
    e.lo = p[7:0];
    e.hi = p[15:8];
    e.fl = {p == 16'h0, p[15], p[15:8] != 8'h00, 1'b0};
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] hold_lo;
    logic [3:0] hold_fl;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_a     = 8'h00;
    req_b     = 8'h00;
    rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_lo, rsp_hi, rsp_flags}, 0);
    chk("rst_alu", {alu_s, alu_a, alu_b}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add", 4'h0, 8'h7F, 8'h01,
           '{8'h80, 8'h00, 4'b0101});
    run_op("sub", 4'h1, 8'h05, 8'h05,
           '{8'h00, 8'h00, 4'b1010});
    run_op("and", 4'h2, 8'hF0, 8'h3C,
           '{8'h30, 8'h00, 4'b0000});
    run_op("undef", 4'hA, 8'h12, 8'h34,
           '{8'h00, 8'h00, 4'b1000});
    run_op("mul_ff", 4'hF, 8'hFF, 8'hFF,
           '{8'h01, 8'hFE, 4'b0110});
    run_op("mul_10", 4'hF, 8'h10, 8'h10,
           '{8'h00, 8'h01, 4'b0010});
    run_op("mul_0", 4'hF, 8'h00, 8'h37,
           '{8'h00, 8'h00, 4'b1000});
    run_op("mul_small", 4'hF, 8'h0B, 8'h0D,
           mul_model(8'h0B, 8'h0D));
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("mul_rnd", 4'hF, ra, rb, mul_model(ra, rb));
    end

    // response consumer already ready before rsp_valid
    sb.push_back('{8'h2A, 8'h00, 4'b0000});
    rsp_ready = 1'b1;
    issue("pre_rdy", 4'h3, 8'h28, 8'h02, 1);
    cmp_rsp("pre_rdy");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("pre_rdy_done", {req_ready, rsp_valid}, 2'b10);

    // backpressure with extra requests pulsed
    sb.push_back('{8'h33, 8'h00, 4'b0000});
    issue("bp", 4'h0, 8'h11, 8'h22, 1);
    cmp_rsp("bp");
    hold_lo = rsp_lo;
    hold_fl = rsp_flags;
    req_op  = 4'h0;
    req_a   = 8'hAA;
    req_b   = 8'h55;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_lo", rsp_lo, 8'h33);
      chk("bp_fl", rsp_flags, 4'b0000);
    end
    req_valid = 1'b0;
    chk("bp_stable", {rsp_lo, rsp_flags}, {hold_lo, hold_fl});
    finish_rsp("bp");
    @(posedge clk); #1;
    chk("bp_no_extra", {req_ready, rsp_valid}, 2'b10);

    // reset in the middle of a multiply
    req_op    = 4'hF;
    req_a     = 8'hFF;
    req_b     = 8'hFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_alu", {alu_s, alu_a, alu_b}, 0);
    chk("mid_rst_rsp", {rsp_lo, rsp_hi, rsp_flags}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst", 4'h0, 8'h01, 8'h02,
           '{8'h03, 8'h00, 4'b0000});
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
